// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states and access legality.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_RESP = 2'd3
    } state_t;

    // 1 when the access is misaligned or the funct3 is not legal for its direction.
    function automatic logic lsu_is_err(input logic we, input logic [2:0] f3,
                                        input logic [1:0] lane);
        logic err;
        err = 1'b1;
        case (f3)
            F3_B:    err = 1'b0;
            F3_H:    err = lane[0];
            F3_W:    err = (lane != 2'b00);
            F3_BU:   err = we;
            F3_HU:   err = we | lane[0];
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load extraction/extension and sub-word store merge.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  lane,
    input  logic [31:0] mem_word,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Pick the addressed byte and half out of the memory word.
    always_comb begin
        sel_byte = mem_word[7:0];
        case (lane)
            2'd0: sel_byte = mem_word[7:0];
            2'd1: sel_byte = mem_word[15:8];
            2'd2: sel_byte = mem_word[23:16];
            2'd3: sel_byte = mem_word[31:24];
            default: sel_byte = mem_word[7:0];
        endcase
        sel_half = lane[1] ? mem_word[31:16] : mem_word[15:0];
    end

    // Extend the selected lane according to the load type.
    always_comb begin
        load_data = 32'h0;
        case (funct3)
            F3_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
            F3_H:    load_data = {{16{sel_half[15]}}, sel_half};
            F3_W:    load_data = mem_word;
            F3_BU:   load_data = {24'h0, sel_byte};
            F3_HU:   load_data = {16'h0, sel_half};
            default: load_data = 32'h0;
        endcase
    end

    // Replace only the addressed lane of the old word; everything else passes through.
    always_comb begin
        store_word = store_data;
        case (funct3[1:0])
            2'b00: begin
                store_word = mem_word;
                case (lane)
                    2'd0: store_word[7:0]   = store_data[7:0];
                    2'd1: store_word[15:8]  = store_data[7:0];
                    2'd2: store_word[23:16] = store_data[7:0];
                    2'd3: store_word[31:24] = store_data[7:0];
                    default: store_word = mem_word;
                endcase
            end
            2'b01: begin
                store_word = lane[1] ? {store_data[15:0], mem_word[15:0]}
                                     : {mem_word[31:16], store_data[15:0]};
            end
            default: store_word = store_data;
        endcase
    end

endmodule

// File: rtl/lsu_dmem_ctrl.sv
// Load/store unit in front of a word-organised data memory with whole-word writes only.
module lsu_dmem_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              mem_wr_en,
    output logic [DATA_W-1:0] mem_wr_data
);

    state_t            state;
    logic [ADDR_W-1:0] waddr_q;
    logic [1:0]        lane_q;
    logic [2:0]        funct3_q;
    logic              we_q;
    // Holds store data from accept; for sub-word stores it is overwritten with the merged word.
    logic [31:0]       merge_q;
    logic [31:0]       load_data;
    logic [31:0]       store_word;
    logic              accept;

    // Address bits above the memory range are ignored so accesses wrap.
    logic unused_addr;
    assign unused_addr = ^req_addr[31:ADDR_W+2];

    assign accept = req_valid & req_ready;

    lsu_align u_align (
        .funct3     (funct3_q),
        .lane       (lane_q),
        .mem_word   (mem_rd_data),
        .store_data (merge_q),
        .load_data  (load_data),
        .store_word (store_word)
    );

    // Request/response FSM with latched request fields and registered response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            waddr_q   <= '0;
            lane_q    <= 2'b00;
            funct3_q  <= 3'b000;
            we_q      <= 1'b0;
            merge_q   <= 32'h0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        waddr_q  <= req_addr[ADDR_W+1:2];
                        lane_q   <= req_addr[1:0];
                        funct3_q <= req_funct3;
                        we_q     <= req_we;
                        merge_q  <= req_wdata;
                        if (lsu_is_err(req_we, req_funct3, req_addr[1:0])) begin
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                            state     <= S_RESP;
                        end else if (req_we && req_funct3 == F3_W) begin
                            state <= S_WR;
                        end else begin
                            state <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    if (we_q) begin
                        merge_q <= store_word;
                        state   <= S_WR;
                    end else begin
                        rsp_rdata <= load_data;
                        rsp_err   <= 1'b0;
                        state     <= S_RESP;
                    end
                end
                S_WR: begin
                    rsp_rdata <= '0;
                    rsp_err   <= 1'b0;
                    state     <= S_RESP;
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Handshake and memory strobes decoded from state; gated by rst so a write is dropped at once.
    always_comb begin
        req_ready   = (state == S_IDLE) && !rst;
        rsp_valid   = (state == S_RESP);
        mem_addr    = waddr_q;
        mem_rd_en   = (state == S_RD) && !rst;
        mem_wr_en   = (state == S_WR) && !rst;
        mem_wr_data = mem_wr_en ? merge_q : '0;
    end

endmodule

// File: doc/lsu_dmem_ctrl.md
Name: lsu_dmem_ctrl

Overview:
Load/store unit that sits directly upstream of the word-organised data memory (32 x 32-bit, combinational read, write on posedge clk).
- Takes byte/half/word load and store requests from the execute/memory stage through a valid/ready handshake.
- Checks alignment, converts byte addresses to word addresses, and extracts and sign/zero-extends load data.
- Handles sub-word stores with a read-modify-write sequence, because the memory only supports whole-word writes.
- Returns one response per accepted request.

Parameters:
- ADDR_W, 5, word-address width driven to memory (memory depth = 2**ADDR_W words)
- DATA_W, 32, data width; fixed at 32, the parameter exists for documentation only

Ports:
- clk  in  1  system clock; shared with the data memory
- rst  in  1  reset; asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3 (LB/LH/LW/LBU/LHU; SB/SH/SW)
- req_addr  in  32  byte address
- req_wdata  in  32  store data; uses the low byte, the low half, or the full word
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  misaligned access or illegal funct3, qualified by rsp_valid
- mem_addr  out  ADDR_W  word address to memory
- mem_rd_en  out  1  memory read enable
- mem_rd_data  in  32  memory read data (combinational)
- mem_wr_en  out  1  memory write enable
- mem_wr_data  out  32  full word to write

Behaviour:
- **FSM states:** IDLE, RD, WR, RESP.
  - req_ready = (state==IDLE) and not rst.
  - A request is accepted on a posedge with req_valid & req_ready; addr, funct3, we and wdata are latched.
- **Transitions from IDLE on accept:**
  - Error: -> RESP.
  - Load: -> RD.
  - Word store (SW): -> WR.
  - Sub-word store (SB/SH): -> RD.
- **RD:** mem_rd_en=1. On the clock edge:
  - Load: capture the extracted, extended data into rsp_rdata, then -> RESP.
  - Sub-word store: capture the old word into a merge register, then -> WR.
- **WR:** mem_wr_en=1, mem_wr_data = merged word (or req_wdata for SW). Memory writes on the edge ending WR; then -> RESP.
- **RESP:** rsp_valid=1 for exactly one cycle, then -> IDLE. rsp_rdata and rsp_err hold until the next RESP.
- **Latency**, accept edge T, response cycle following:
  - error: T+1
  - load: T+2
  - SW: T+2
  - SB/SH: T+3
  - Throughput is one request per (latency+1) cycles; a held req_valid is accepted on the first IDLE cycle after RESP.
- **Memory outputs:**
  - mem_addr = latched req_addr[ADDR_W+1:2]; upper address bits are ignored, so addresses wrap modulo memory size.
  - mem_rd_en and mem_wr_en are decoded combinationally from state. They are never both 1, and both are 0 in IDLE and RESP.
  - mem_wr_data = 0 outside WR.
- **Error conditions (rsp_err=1):**
  - LH/LHU/SH with addr[0]=1.
  - LW/SW with addr[1:0]!=0.
  - funct3 in {011, 110, 111} for loads.
  - funct3 not in {000, 001, 010} for stores.
  - On error: no memory access, and rsp_rdata=0.
- **Load extraction:**
  - Byte lane = addr[1:0]; half lane = addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- **Store merge:** only the addressed byte or half of the old word is replaced; all other bits are preserved exactly.
- **Reset values:** state=IDLE; rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_rd_en=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0, req_ready=0 while rst is high.
- **Reset mid-operation:** the in-flight request is dropped and no response is issued. Because mem_wr_en falls combinationally when rst rises, rst asserted during WR before the edge suppresses the write.

Decomposition:
- **Shared package/header (lsu_pkg):**
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101
  - state encodings S_IDLE/S_RD/S_WR/S_RESP
  - the error-check function
- **Sub-module lsu_align** (purely combinational): given funct3, addr[1:0], a memory word and store data, produce the extended load value and the merged store word. lsu_dmem_ctrl instantiates it once and contains the FSM and registers.

Test Plan:
1. **SW:** addr 0x14, data 0xDEADBEEF -> rsp_valid at T+2 with rsp_err=0; memory word 5 = 0xDEADBEEF; mem_wr_en high for exactly 1 cycle.
2. **Byte loads**, after test 1:
   - LB addr 0x17 -> rsp_rdata=0xFFFFFFDE at T+2.
   - LBU addr 0x17 -> 0x000000DE.
   - LHU addr 0x14 -> 0x0000BEEF.
3. **Half store then word load:** SH addr 0x16, data 0xAAAA1234 -> rsp at T+3; word 5 = 0x1234BEEF. A following LW 0x14 returns 0x1234BEEF.
4. **Errors:**
   - LH addr 0x15 -> rsp_valid with rsp_err=1 at T+1, rsp_rdata=0, no mem_rd_en/mem_wr_en pulses.
   - SW addr 0x16 -> same response.
   - Load funct3=011 -> rsp_err=1.
5. **Reset during write:** assert rst during WR of SB addr 0x14, data 0x55 -> word 5 unchanged, no rsp_valid, req_ready returns 1 the cycle after rst falls.
6. **Back-to-back and wrap-around:**
   - req_valid held with SW 0x00 then LW 0x00 -> the second request is accepted the cycle after the first RESP, and the LW returns the stored value.
   - SW addr 0x80 (wraps to word 0) -> the subsequent LW 0x00 returns the new value.
